// File: rtl/eth_pkg.sv
// eth_pkg: shared constants and FSM state type for the Ethernet receive path.
package eth_pkg;

  localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
  localparam logic [7:0]  ETH_SFD         = 8'hD5;
  localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFFFFFF;
  localparam logic [31:0] ETH_CRC_RESIDUE = 32'hC704DD7B;
  localparam logic [31:0] ETH_CRC_POLY    = 32'h04C11DB7;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    PREAMBLE = 2'd1,
    DATA     = 2'd2,
    DROP     = 2'd3
  } state_t;

endpackage

// File: rtl/crc32_byte_step.sv
// crc32_byte_step: one-byte parallel CRC-32 update, G(x)=0x04C11DB7, MSB-first
// register. The byte is consumed bit 0 first, matching wire order, which is the
// same as shifting the bit-reversed byte in MSB-first. No final inversion.
module crc32_byte_step
  import eth_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [7:0]  byte_in,
  output logic [31:0] crc_out
);

  logic [31:0] crc_work;
  logic        fb;

  // Unrolled 8-step LFSR; synthesizes to the flat XOR equations.
  always_comb begin
    crc_work = crc_in;
    fb       = 1'b0;
    for (int i = 0; i < 8; i++) begin
      fb       = crc_work[31] ^ byte_in[i];
      crc_work = {crc_work[30:0], 1'b0} ^ (fb ? ETH_CRC_POLY : 32'h0);
    end
    crc_out = crc_work;
  end

endmodule

// File: rtl/eth_fcs_check.sv
// eth_fcs_check: GMII receive FCS checker. Finds the SFD, runs CRC-32 over all
// following bytes and reports CRC/length status one clock after the last byte.
// Optional FCS_STRIP_EN: emits the frame bytes with the trailing 4-byte FCS
// removed through a 4-byte delay line (dout_valid/dout_data).
module eth_fcs_check #(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 1518
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_en,
  input  logic [7:0]  rx_data,
  output logic        frame_done,
  output logic        frame_ok,
  output logic        crc_err,
  output logic        short_err,
  output logic        long_err,
  output logic [15:0] frame_len,
  output logic        dout_valid,
  output logic [7:0]  dout_data
);
  import eth_pkg::*;

  localparam logic [15:0] MIN_LEN16 = 16'(MIN_LEN);
  localparam logic [15:0] MAX_LEN16 = 16'(MAX_LEN);

  state_t      state_reg;
  logic [31:0] crc_reg;
  logic [31:0] crc_next;
  logic [15:0] len_reg;
  logic        crc_bad;
  logic        len_short;
  logic        len_long;

  crc32_byte_step u_crc (
    .crc_in  (crc_reg),
    .byte_in (rx_data),
    .crc_out (crc_next)
  );

  assign crc_bad   = (crc_reg != ETH_CRC_RESIDUE);
  assign len_short = (len_reg < MIN_LEN16);
  assign len_long  = (len_reg > MAX_LEN16);

  // Frame FSM with CRC register, length counter and registered result flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      crc_reg    <= ETH_CRC_INIT;
      len_reg    <= 16'd0;
      frame_done <= 1'b0;
      frame_ok   <= 1'b0;
      crc_err    <= 1'b0;
      short_err  <= 1'b0;
      long_err   <= 1'b0;
      frame_len  <= 16'd0;
    end else begin
      frame_done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (rx_en) begin
            state_reg <= (rx_data == ETH_PREAMBLE) ? PREAMBLE : DROP;
          end
        end
        PREAMBLE: begin
          if (!rx_en) begin
            state_reg <= IDLE;
          end else if (rx_data == ETH_SFD) begin
            state_reg <= DATA;
            crc_reg   <= ETH_CRC_INIT;
            len_reg   <= 16'd0;
          end else if (rx_data != ETH_PREAMBLE) begin
            state_reg <= DROP;
          end
        end
        DATA: begin
          if (rx_en) begin
            crc_reg <= crc_next;
            if (len_reg != 16'hFFFF) begin
              len_reg <= len_reg + 16'd1;
            end
          end else begin
            // Frame end: latch the verdict, it holds until the next frame.
            state_reg  <= IDLE;
            frame_done <= 1'b1;
            crc_err    <= crc_bad;
            short_err  <= len_short;
            long_err   <= len_long;
            frame_ok   <= !(crc_bad || len_short || len_long);
            frame_len  <= len_reg;
          end
        end
        DROP: begin
          if (!rx_en) begin
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef FCS_STRIP_EN
  logic [7:0] dly_reg [4];
  logic [2:0] fill_reg;
  logic       shift_en;
  logic       sfd_hit;

  assign shift_en = (state_reg == DATA) && rx_en;
  assign sfd_hit  = (state_reg == PREAMBLE) && rx_en && (rx_data == ETH_SFD);

  // Delay line: once four bytes are held, each new byte releases the oldest.
  // The last four bytes of a frame (the FCS) are never released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) dly_reg[i] <= 8'd0;
      fill_reg   <= 3'd0;
      dout_valid <= 1'b0;
      dout_data  <= 8'd0;
    end else begin
      dout_valid <= 1'b0;
      if (sfd_hit) begin
        for (int i = 0; i < 4; i++) dly_reg[i] <= 8'd0;
        fill_reg <= 3'd0;
      end else if (shift_en) begin
        dly_reg[0] <= rx_data;
        for (int i = 1; i < 4; i++) dly_reg[i] <= dly_reg[i-1];
        if (fill_reg == 3'd4) begin
          dout_valid <= 1'b1;
          dout_data  <= dly_reg[3];
        end else begin
          fill_reg <= fill_reg + 3'd1;
        end
      end
    end
  end
`else
  assign dout_valid = 1'b0;
  assign dout_data  = 8'd0;
`endif

endmodule

// File: tb/tb_eth_fcs_check.sv
// tb_eth_fcs_check: directed bench for eth_fcs_check. The reference FCS is
// produced with the reflected (LSB-first, 0xEDB88320) CRC-32 form.
`timescale 1ns/1ps
module tb_eth_fcs_check;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        rx_en = 1'b0;
  logic [7:0]  rx_data = 8'd0;
  logic        frame_done;
  logic        frame_ok;
  logic        crc_err;
  logic        short_err;
  logic        long_err;
  logic [15:0] frame_len;
  logic        dout_valid;
  logic [7:0]  dout_data;

  eth_fcs_check dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_en      (rx_en),
    .rx_data    (rx_data),
    .frame_done (frame_done),
    .frame_ok   (frame_ok),
    .crc_err    (crc_err),
    .short_err  (short_err),
    .long_err   (long_err),
    .frame_len  (frame_len),
    .dout_valid (dout_valid),
    .dout_data  (dout_data)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0]  frame_q[$];
  logic [3:0]  done_flags_q[$];   // {ok, crc, short, long}
  logic [15:0] done_len_q[$];
  int          done_cyc_q[$];
  logic [7:0]  dout_q[$];
  int          last_cyc;
  int          last_cyc_a;

  // Capture every result pulse and stripped byte on the falling edge.
  always @(negedge clk) begin
    if (frame_done) begin
      done_flags_q.push_back({frame_ok, crc_err, short_err, long_err});
      done_len_q.push_back(frame_len);
      done_cyc_q.push_back(cyc);
    end
    if (dout_valid) dout_q.push_back(dout_data);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_en   = 1'b1;
    rx_data = b;
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    rx_en   = 1'b0;
    rx_data = 8'd0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_preamble();
    repeat (7) send_byte(8'h55);
    send_byte(8'hD5);
  endtask

  task automatic send_frame();
    send_preamble();
    foreach (frame_q[i]) send_byte(frame_q[i]);
    last_cyc = cyc;
  endtask

  // Payload of total-4 pattern bytes followed by the correct FCS, low byte first.
  task automatic build_frame(input int total, input int seed);
    logic [31:0] c;
    logic [7:0]  b;
    frame_q.delete();
    c = 32'hFFFFFFFF;
    for (int i = 0; i < total - 4; i++) begin
      b = 8'((i * 7 + 3 + seed) & 255);
      frame_q.push_back(b);
      c = c ^ {24'd0, b};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    c = ~c;
    for (int j = 0; j < 4; j++) frame_q.push_back(c[8*j +: 8]);
  endtask

  task automatic expect_frame(input string tag, input logic [3:0] flags, input logic [15:0] len,
                              input int end_cyc);
    check({tag, "_count"}, 32'(done_flags_q.size()), 32'd1);
    if (done_flags_q.size() != 0) begin
      check({tag, "_flags"}, 32'(done_flags_q.pop_front()), 32'(flags));
      check({tag, "_len"}, 32'(done_len_q.pop_front()), 32'(len));
      check({tag, "_latency"}, 32'(done_cyc_q.pop_front() - end_cyc), 32'd1);
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {8'd0, frame_done, frame_ok, crc_err, short_err, long_err,
                            frame_len, dout_valid}, 32'd0);
    check("reset_dout_data", 32'(dout_data), 32'd0);
    rst_n = 1'b1;
    gap(2);

    // Good 64-byte frame
    build_frame(64, 0);
    dout_q.delete();
    send_frame();
    gap(3);
    expect_frame("good64", 4'b1000, 16'd64, last_cyc);
`ifdef FCS_STRIP_EN
    check("strip_count", 32'(dout_q.size()), 32'd60);
    for (int i = 0; i < 60 && i < dout_q.size(); i++)
      check($sformatf("strip_byte%0d", i), 32'(dout_q[i]), 32'(frame_q[i]));
`else
    check("nostrip_count", 32'(dout_q.size()), 32'd0);
`endif

    // Bit 3 of byte 20 flipped
    build_frame(64, 0);
    frame_q[20] = frame_q[20] ^ 8'h08;
    send_frame();
    gap(3);
    expect_frame("badcrc", 4'b0100, 16'd64, last_cyc);
    check("badcrc_hold", 32'(crc_err), 32'd1);

    // 63-byte frame with valid FCS
    build_frame(63, 5);
    send_frame();
    gap(3);
    expect_frame("short63", 4'b0010, 16'd63, last_cyc);

    // 1519-byte frame with valid FCS
    build_frame(1519, 9);
    send_frame();
    gap(3);
    expect_frame("long1519", 4'b0001, 16'd1519, last_cyc);

    // Zero-byte frame: SFD then rx_en low
    send_preamble();
    last_cyc = cyc;
    gap(3);
    expect_frame("zero", 4'b0110, 16'd0, last_cyc);

    // Broken preamble 55 55 57 ... must not produce a result; flags hold
    send_byte(8'h55);
    send_byte(8'h55);
    send_byte(8'h57);
    send_byte(8'hD5);
    for (int i = 0; i < 10; i++) send_byte(8'(i + 1));
    gap(3);
    check("badpre_count", 32'(done_flags_q.size()), 32'd0);
    check("badpre_hold", {28'd0, frame_ok, crc_err, short_err, long_err}, 32'b0110);

    // Two good frames separated by a single idle cycle
    build_frame(64, 17);
    send_frame();
    last_cyc_a = last_cyc;
    gap(1);
    build_frame(70, 33);
    send_frame();
    gap(3);
    check("b2b_count", 32'(done_flags_q.size()), 32'd2);
    if (done_flags_q.size() == 2) begin
      check("b2b_a_flags", 32'(done_flags_q.pop_front()), 32'b1000);
      check("b2b_a_len", 32'(done_len_q.pop_front()), 32'd64);
      check("b2b_a_latency", 32'(done_cyc_q.pop_front() - last_cyc_a), 32'd1);
      expect_frame("b2b_b", 4'b1000, 16'd70, last_cyc);
    end

    // Reset pulsed after byte 30 of a frame; trailing bytes fall into DROP
    build_frame(64, 0);
    send_preamble();
    for (int i = 0; i < 30; i++) send_byte(frame_q[i]);
    rst_n = 1'b0;
    #1;
    check("rst_mid_outputs", {8'd0, frame_done, frame_ok, crc_err, short_err, long_err,
                              frame_len, dout_valid}, 32'd0);
    send_byte(frame_q[30]);
    send_byte(frame_q[31]);
    rst_n = 1'b1;
    for (int i = 32; i < 64; i++) send_byte(frame_q[i]);
    gap(3);
    check("rst_mid_count", 32'(done_flags_q.size()), 32'd0);
    check("rst_mid_after", {8'd0, frame_done, frame_ok, crc_err, short_err, long_err,
                            frame_len, dout_valid}, 32'd0);

    // Recovery: a good frame after the aborted one
    build_frame(64, 3);
    send_frame();
    gap(3);
    expect_frame("recover", 4'b1000, 16'd64, last_cyc);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
